// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: a synchronized falling edge starts a frame, the start bit
// is re-checked at its midpoint, and the data and stop bits are sampled one baud period apart.
module uart_rx #(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int HALF = BAUD / 2;
  localparam int CW   = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          rx_s1;
  logic          rxs;
  logic          rxs_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;

  // cnt reaches zero exactly on each sampling cycle; loads are one less than the spacing
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      data   <= 8'h00;
      rcv    <= 1'b0;
      ferr   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      rcv   <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        IDLE: begin
          // Only a real falling edge starts a frame, so a held-low line (break) is ignored
          if (rxs_d && !rxs) begin
            cnt   <= HALF_LD;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rxs) begin
            cnt    <= BAUD_LD;
            bitcnt <= '0;
            state  <= DATA;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift  <= {rxs, shift[7:1]};
            cnt    <= BAUD_LD;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rxs) begin
              data <= shift;
              rcv  <= 1'b1;
            end else begin
              ferr <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD=8: framed bytes, back-to-back frames, start glitch,
// bad stop bit, line break and reset in mid-frame.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  uart_rx #(.BAUD(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         rcv_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         data_bad = 0;
  int         ferr_cyc = 0;
  int         rcyc[16];
  logic [7:0] rdat[16];
  logic [7:0] prev_data;
  logic       prev_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rcv === 1'b1) begin
      rcyc[rcv_cnt & 15] = cyc;
      rdat[rcv_cnt & 15] = data;
      rcv_cnt = rcv_cnt + 1;
    end
    if (ferr === 1'b1) begin
      ferr_cyc = cyc;
      ferr_cnt = ferr_cnt + 1;
    end
    if (rcv === 1'b1 && ferr === 1'b1) both_cnt = both_cnt + 1;
    if (data !== prev_data && rcv !== 1'b1 && !rst && !prev_rst) data_bad = data_bad + 1;
    prev_data = data;
    prev_rst  = rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns on the edge that ends the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int st);
    #1 rx = 1'b0;
    st = cyc;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (8) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (8) @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1 rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  int st0, st1;
  logic [7:0] b6;

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    check("reset_data", data, 8'h00);
    check("reset_rcv", rcv, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Single clean frame
    send_frame(8'h55, 1'b1, st0);
    idle(4);
    check("f55_count", rcv_cnt, 1);
    check("f55_data", data, 8'h55);
    check("f55_latency", rcyc[0] - st0, 79);
    check("f55_noferr", ferr_cnt, 0);
    check("f55_busy_idle", busy, 1'b0);

    // Start glitch: low for 3 clk only
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    @(posedge clk);
    #1 check("glitch_busy_hi", busy, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("glitch_busy_lo", busy, 1'b0);
    idle(10);
    check("glitch_no_rcv", rcv_cnt, 1);
    check("glitch_no_ferr", ferr_cnt, 0);
    send_frame(8'h3C, 1'b1, st0);
    idle(4);
    check("f3c_count", rcv_cnt, 2);
    check("f3c_data", data, 8'h3C);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1, st0);
    send_frame(8'h0F, 1'b1, st1);
    idle(4);
    check("b2b_count", rcv_cnt, 4);
    check("b2b_first", rdat[2], 8'hA3);
    check("b2b_second", rdat[3], 8'h0F);
    check("b2b_spacing", rcyc[3] - rcyc[2], 80);
    check("b2b_data", data, 8'h0F);

    // Bad stop bit
    send_frame(8'h81, 1'b0, st0);
    idle(16);
    check("stop0_ferr", ferr_cnt, 1);
    check("stop0_latency", ferr_cyc - st0, 79);
    check("stop0_no_rcv", rcv_cnt, 4);
    check("stop0_data_kept", data, 8'h0F);
    send_frame(8'h7E, 1'b1, st0);
    idle(4);
    check("f7e_count", rcv_cnt, 5);
    check("f7e_data", data, 8'h7E);

    // Break: line held low, only one frame error, break byte not delivered
    #1 rx = 1'b0;
    repeat (200) @(posedge clk);
    check("break_ferr", ferr_cnt, 2);
    check("break_no_rcv", rcv_cnt, 5);
    check("break_data_kept", data, 8'h7E);
    check("break_busy", busy, 1'b0);
    idle(20);
    check("break_release_ferr", ferr_cnt, 2);

    // Reset during data bit 4
    b6 = 8'hC6;
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 rx = b6[i];
      repeat (i == 4 ? 4 : 8) @(posedge clk);
    end
    #1 rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 check("rst_busy", busy, 1'b0);
    check("rst_data", data, 8'h00);
    rst = 1'b0;
    idle(100);
    check("rst_no_rcv", rcv_cnt, 5);
    check("rst_no_ferr", ferr_cnt, 2);
    send_frame(8'h99, 1'b1, st0);
    idle(4);
    check("f99_count", rcv_cnt, 6);
    check("f99_data", data, 8'h99);

    check("rcv_ferr_overlap", both_cnt, 0);
    check("data_only_on_rcv", data_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
